// File: rtl/opcode_sequencer.sv
// Opcode sequencer: registers fetched opcodes, expands CALL/RET/RTI into
// two-part ops and injects a two-part interrupt sequence.
module opcode_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        int_req,
  output logic [4:0]  opCode,
  output logic [15:0] instr_out,
  output logic        valid_out,
  output logic        pc_hold,
  output logic        busy
);

  typedef enum logic [2:0] {
    PASS  = 3'd0,
    CALL2 = 3'd1,
    RET2  = 3'd2,
    RTI2  = 3'd3,
    INT2  = 3'd4
  } state_t;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALLB = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RETB  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTIB  = 5'b11101;
  localparam logic [4:0] OP_INTA  = 5'b11110;
  localparam logic [4:0] OP_INTB  = 5'b11111;

  state_t     state;
  logic       int_pending;
  logic [4:0] op_in;
  logic       internal_op;

  assign op_in = instr_in[15:11];

  // Second-part and interrupt opcodes must never come from fetch.
  assign internal_op = (op_in == OP_CALLB) || (op_in == OP_RETB) ||
                       (op_in == OP_RTIB)  || (op_in == OP_INTA) ||
                       (op_in == OP_INTB);

  // Fetch is held while a second part or an interrupt is pending.
  assign busy    = (state != PASS);
  assign pc_hold = busy || int_pending || stall;

  // Sequencer state, registered outputs and interrupt latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PASS;
      opCode      <= OP_NOP;
      instr_out   <= 16'h0000;
      valid_out   <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      if (flush) begin
        state     <= PASS;
        opCode    <= OP_NOP;
        instr_out <= 16'h0000;
        valid_out <= 1'b0;
      end else if (!stall) begin
        unique case (state)
          PASS: begin
            if (int_pending) begin
              opCode      <= OP_INTA;
              instr_out   <= 16'h0000;
              valid_out   <= 1'b1;
              state       <= INT2;
              int_pending <= 1'b0;
            end else if (instr_valid) begin
              instr_out <= instr_in;
              valid_out <= 1'b1;
              if (internal_op) begin
                opCode <= OP_NOP;
                state  <= PASS;
              end else begin
                opCode <= op_in;
                if (op_in == OP_CALL)
                  state <= CALL2;
                else if (op_in == OP_RET)
                  state <= RET2;
                else if (op_in == OP_RTI)
                  state <= RTI2;
                else
                  state <= PASS;
              end
            end else begin
              opCode    <= OP_NOP;
              valid_out <= 1'b0;
            end
          end
          CALL2: begin
            opCode    <= OP_CALLB;
            valid_out <= 1'b1;
            state     <= PASS;
          end
          RET2: begin
            opCode    <= OP_RETB;
            valid_out <= 1'b1;
            state     <= PASS;
          end
          RTI2: begin
            opCode    <= OP_RTIB;
            valid_out <= 1'b1;
            state     <= PASS;
          end
          INT2: begin
            opCode    <= OP_INTB;
            valid_out <= 1'b1;
            state     <= PASS;
          end
          default: begin
            state <= PASS;
          end
        endcase
      end
      // A request in the same cycle always wins over the clear above.
      if (int_req)
        int_pending <= 1'b1;
    end
  end

endmodule
